// File: rtl/mem_if_pkg.sv
// Shared encodings for the memory access controller: request types,
// controller states and the default RAM word-index width.
package mem_if_pkg;

   localparam int ADDR_W_DEFAULT = 9;

   typedef logic [1:0] req_type_t;

   localparam req_type_t REQ_FETCH = 2'b00;
   localparam req_type_t REQ_LOAD  = 2'b01;
   localparam req_type_t REQ_STORE = 2'b10;
   localparam req_type_t REQ_RSVD  = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_WAIT  = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

   // Reserved encoding is the only type the controller refuses outright.
   function automatic logic type_is_legal(input req_type_t t);
      return t != REQ_RSVD;
   endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the unified instruction/data RAM of the multi-cycle
// datapath. Sequences fetch/load/store through ISSUE and WAIT so the address
// is held across the RAM's one-cycle read latency, then offers a valid/ready
// response. Strobes are decoded from the current state.
module mem_access_ctrl
   import mem_if_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEFAULT,
   parameter int RANGE_CHECK = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_type,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_data,
   output logic             resp_err,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IorD,
   output logic             IRWrite,
   output logic [31:0]      PC,
   output logic [31:0]      ALUOut,
   output logic [31:0]      wdata,
   input  logic [31:0]      dataout,
   output logic [CNT_W-1:0] acc_cnt
);

   state_t      state;
   req_type_t   type_q;
   logic [31:0] addr_hi;
   logic        range_fault;
   logic        reject;

   // Address bits above the RAM index must be zero when range checking is on.
   assign addr_hi     = req_addr >> ADDR_W;
   assign range_fault = (RANGE_CHECK != 0) && (addr_hi != 32'd0);
   assign reject      = !type_is_legal(req_type) || range_fault;

   assign req_ready  = (state == ST_IDLE) && !rst;
   assign resp_valid = (state == ST_RESP);

   // Memory strobes; write and IR latch are suppressed by reset in the same cycle.
   always_comb begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      case (state)
         ST_ISSUE: begin
            MemRead  = (type_q != REQ_STORE);
            MemWrite = (type_q == REQ_STORE) && !rst;
            IorD     = (type_q != REQ_FETCH);
         end
         ST_WAIT: begin
            MemRead = 1'b1;
            IorD    = (type_q != REQ_FETCH);
            IRWrite = (type_q == REQ_FETCH) && !rst;
         end
         default: ;
      endcase
   end

   // Transaction sequencer with its address, write-data, response and count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         type_q    <= REQ_FETCH;
         resp_data <= 32'd0;
         resp_err  <= 1'b0;
         PC        <= 32'd0;
         ALUOut    <= 32'd0;
         wdata     <= 32'd0;
         acc_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  type_q    <= req_type;
                  resp_data <= 32'd0;
                  if (reject) begin
                     // Rejected requests leave the address/data registers untouched.
                     resp_err <= 1'b1;
                     state    <= ST_RESP;
                  end else begin
                     resp_err <= 1'b0;
                     state    <= ST_ISSUE;
                     if (req_type == REQ_FETCH) begin
                        PC <= req_addr;
                     end else begin
                        ALUOut <= req_addr;
                     end
                     if (req_type == REQ_STORE) begin
                        wdata <= req_wdata;
                     end
                  end
               end
            end
            ST_ISSUE: begin
               state <= (type_q == REQ_STORE) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
               // Read data appears one cycle after ISSUE presented the address.
               if (type_q == REQ_LOAD) begin
                  resp_data <= dataout;
               end
               state <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state <= ST_IDLE;
                  if (!resp_err) begin
                     acc_cnt <= acc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a synchronous RAM with IR register stands in for
// the memory block, and a transaction-level model predicts every response,
// latency, strobe count and register value.
module tb_mem_access_ctrl;
   import mem_if_pkg::*;

   localparam int AW = 9;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_type;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [31:0]   resp_data;
   logic          resp_err;
   logic          MemRead;
   logic          MemWrite;
   logic          IorD;
   logic          IRWrite;
   logic [31:0]   PC;
   logic [31:0]   ALUOut;
   logic [31:0]   wdata;
   logic [31:0]   dataout;
   logic [CW-1:0] acc_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_W(AW), .RANGE_CHECK(1), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_err(resp_err),
      .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
      .PC(PC), .ALUOut(ALUOut), .wdata(wdata), .dataout(dataout),
      .acc_cnt(acc_cnt)
   );

   // Memory block: synchronous RAM, IR register and a preload port.
   logic [31:0] ram [0:511];
   logic [31:0] ir;
   logic        ld_en;
   logic [8:0]  ld_idx;
   logic [31:0] ld_val;
   wire  [31:0] bus_addr = IorD ? ALUOut : PC;

   always @(posedge clk) begin
      if (ld_en) ram[ld_idx] <= ld_val;
      else if (MemWrite) ram[bus_addr[8:0]] <= wdata;
      dataout <= ram[bus_addr[8:0]];
      if (IRWrite) ir <= dataout;
   end

   // Transaction-level reference state.
   logic [31:0] ref_mem [0:511];
   logic [31:0] ref_ir, ref_pc, ref_alu, ref_wd;
   int          ref_cnt;

   // Per-transaction strobe observations.
   int          n_rd, n_wr, n_ir, bad_iord, bad_addr;
   logic [1:0]  cur_t;
   logic [31:0] cur_a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sample_strobes();
      if (MemRead)  n_rd++;
      if (MemWrite) n_wr++;
      if (IRWrite)  n_ir++;
      if ((MemRead || MemWrite) && (IorD !== (cur_t != REQ_FETCH))) bad_iord++;
      if ((MemRead || MemWrite) && (bus_addr !== cur_a)) bad_addr++;
   endtask

   // Runs one request from IDLE through its response handshake; called at posedge+1.
   task automatic do_req(input logic [1:0] t, input logic [31:0] a,
                         input logic [31:0] d, input int stall);
      int          lat;
      logic        exp_err;
      int          exp_lat;
      logic [31:0] exp_data;
      logic [31:0] held;
      exp_err  = (t == 2'b11) || (a >= 32'd512);
      exp_lat  = exp_err ? 1 : (t == REQ_STORE) ? 2 : 3;
      exp_data = (!exp_err && t == REQ_LOAD) ? ref_mem[a[8:0]] : 32'd0;
      n_rd = 0; n_wr = 0; n_ir = 0; bad_iord = 0; bad_addr = 0;
      cur_t = t; cur_a = a;

      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = d;
      resp_ready = (stall == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 10) begin
         sample_strobes();
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
      chk("resp_data", resp_data, exp_data);
      held = resp_data;

      for (int i = 0; i < stall; i++) begin
         sample_strobes();
         if (i == 0) begin
            // A competing request offered while busy must be ignored.
            req_valid = 1'b1; req_type = REQ_FETCH; req_addr = 32'd1;
         end
         @(posedge clk); #1;
         chk("stall_valid", {31'd0, resp_valid}, 32'd1);
         chk("stall_data", resp_data, held);
         chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      sample_strobes();
      resp_ready = 1'b1;
      @(posedge clk); #1;

      if (!exp_err) begin
         ref_cnt = (ref_cnt + 1) % (1 << CW);
         case (t)
            REQ_FETCH: begin ref_pc = a; ref_ir = ref_mem[a[8:0]]; end
            REQ_LOAD:  ref_alu = a;
            default: begin ref_alu = a; ref_wd = d; ref_mem[a[8:0]] = d; end
         endcase
      end

      chk("post_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("post_req_ready", {31'd0, req_ready}, 32'd1);
      chk("acc_cnt", {28'd0, acc_cnt}, ref_cnt);
      chk("PC", PC, ref_pc);
      chk("ALUOut", ALUOut, ref_alu);
      chk("wdata", wdata, ref_wd);
      chk("n_memread", n_rd, (!exp_err && t != REQ_STORE) ? 2 : 0);
      chk("n_memwrite", n_wr, (!exp_err && t == REQ_STORE) ? 1 : 0);
      chk("n_irwrite", n_ir, (!exp_err && t == REQ_FETCH) ? 1 : 0);
      chk("bad_iord", bad_iord, 0);
      chk("bad_addr", bad_addr, 0);
      if (!exp_err && t == REQ_FETCH) chk("ir", ir, ref_ir);
   endtask

   initial begin
      logic [1:0]  rt;
      logic [31:0] ra;
      rst = 1'b1; req_valid = 1'b0; req_type = 2'b00; req_addr = 32'd0;
      req_wdata = 32'd0; resp_ready = 1'b1; ld_en = 1'b0; ld_idx = 9'd0; ld_val = 32'd0;
      ref_ir = 32'd0; ref_pc = 32'd0; ref_alu = 32'd0; ref_wd = 32'd0; ref_cnt = 0;

      // Preload RAM while reset is held.
      @(posedge clk); #1;
      for (int i = 0; i < 512; i++) begin
         ld_en = 1'b1; ld_idx = i[8:0];
         ld_val = (i == 16) ? 32'h8C01_0004 : $urandom;
         ref_mem[i] = ld_val;
         @(posedge clk); #1;
      end
      ld_en = 1'b0;

      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_strobes", {28'd0, MemRead, MemWrite, IorD, IRWrite}, 32'd0);
      chk("rst_PC", PC, 32'd0);
      chk("rst_acc_cnt", {28'd0, acc_cnt}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed: fetch, store/load round trip, rejections, backpressure.
      do_req(REQ_FETCH, 32'h10, 32'd0, 0);
      chk("ir_fetch_0x10", ir, 32'h8C01_0004);
      do_req(REQ_STORE, 32'h20, 32'hDEAD_BEEF, 0);
      do_req(REQ_LOAD, 32'h20, 32'd0, 0);
      do_req(REQ_LOAD, 32'h200, 32'd0, 0);
      do_req(2'b11, 32'h05, 32'd0, 0);
      do_req(REQ_LOAD, 32'h05, 32'd0, 5);

      // Reset during a store's ISSUE cycle must suppress the write.
      req_valid = 1'b1; req_type = REQ_STORE; req_addr = 32'h30; req_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("memwrite_in_rst", {31'd0, MemWrite}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      ref_pc = 32'd0; ref_alu = 32'd0; ref_wd = 32'd0; ref_cnt = 0;
      chk("after_rst_PC", PC, 32'd0);
      chk("after_rst_ALUOut", ALUOut, 32'd0);
      chk("after_rst_wdata", wdata, 32'd0);
      chk("after_rst_resp", {29'd0, resp_valid, resp_err, MemRead}, 32'd0);
      chk("after_rst_resp_data", resp_data, 32'd0);
      chk("after_rst_acc_cnt", {28'd0, acc_cnt}, 32'd0);
      chk("after_rst_req_ready", {31'd0, req_ready}, 32'd1);
      do_req(REQ_LOAD, 32'h30, 32'd0, 0);

      // Counter wrap: bring it to all-ones, then one more load.
      for (int i = 0; i < 14; i++) do_req(REQ_FETCH, $urandom_range(0, 511), 32'd0, 0);
      chk("acc_cnt_all_ones", {28'd0, acc_cnt}, 32'd15);
      do_req(REQ_LOAD, 32'h20, 32'd0, 0);
      chk("acc_cnt_wrapped", {28'd0, acc_cnt}, 32'd0);

      // Randomized mix over a small address window so stores and loads collide.
      for (int i = 0; i < 40; i++) begin
         rt = $urandom_range(0, 3);
         case ($urandom_range(0, 9))
            0:       ra = 32'h200 + $urandom_range(0, 1000);
            1:       ra = $urandom | 32'h8000_0000;
            default: ra = $urandom_range(0, 31);
         endcase
         do_req(rt, ra, $urandom, $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
CPU-side initiator for the multi-cycle datapath's unified instruction/data memory block. It accepts fetch/load/store requests from the control path and drives the memory strobes (MemRead, MemWrite, IorD, IRWrite), the address sources (PC, ALUOut) and the write data. It sequences the one-cycle synchronous-RAM read latency, holds the address stable, and returns load data or completion through a valid/ready response.

Parameters:
ADDR_W, 9, RAM word-index width; memory decodes addr[ADDR_W-1:0].
RANGE_CHECK, 1, 1 = reject requests with addr[31:ADDR_W] != 0.
CNT_W, 16, width of the completed-access counter.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request offered.
req_ready  out  1  controller can accept a request (IDLE only).
req_type  in  2  00 fetch, 01 load, 10 store, 11 reserved.
req_addr  in  32  word address.
req_wdata  in  32  store data.
resp_valid  out  1  response available.
resp_ready  in  1  consumer takes response.
resp_data  out  32  load data; 0 for fetch/store/error.
resp_err  out  1  request rejected (reserved type or range).
MemRead  out  1  memory read strobe.
MemWrite  out  1  memory write enable.
IorD  out  1  0 = PC addresses memory, 1 = ALUOut.
IRWrite  out  1  memory latches instruction into IR.
PC  out  32  fetch address.
ALUOut  out  32  data address.
wdata  out  32  memory write data.
dataout  in  32  memory read data (synchronous, 1-cycle latency).
acc_cnt  out  CNT_W  completed non-error accesses, wraps.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. req_ready = (state==IDLE) && !rst.
- Accept on req_valid && req_ready: latch type/addr/wdata. Fetch: PC <= addr. Load/store: ALUOut <= addr. Store also latches wdata. Reserved type or range fault (RANGE_CHECK=1): go directly to RESP with resp_err=1. No strobe is asserted and PC/ALUOut/wdata are not modified.
- ISSUE (1 cycle): MemRead=1 for fetch/load; MemWrite=1 for store; IorD=0 fetch, 1 otherwise. Store goes to RESP; fetch/load go to WAIT.
- WAIT (1 cycle): address and IorD held; MemRead=1. Fetch: IRWrite=1 for exactly this cycle. Load: resp_data <= dataout at the closing edge. Next state is RESP.
- RESP: resp_valid=1; hold resp_data/resp_err stable until resp_valid && resp_ready, then go to IDLE. acc_cnt increments by 1 on that handshake when resp_err=0. It wraps from all-ones to 0.
- Latency, accept edge to resp_valid: fetch/load 3 cycles, store 2, error 1. With resp_ready tied high, back-to-back throughput is fetch/load 1 per 4 cycles and store 1 per 3.
- Strobes are decoded from state. In IDLE/RESP all strobes are 0. PC, ALUOut and wdata hold their last values between requests.
- MemWrite = (state==ISSUE && store) && !rst. Reset during a store ISSUE suppresses the write at that edge. IRWrite is gated by !rst in the same way.
- Reset values: state IDLE; resp_valid, resp_err, all strobes 0; resp_data, PC, ALUOut, wdata = 0; acc_cnt = 0. Reset mid-transaction abandons it with no response.
- req_valid while not ready is ignored; the request is not queued.

Decomposition:
- Shared package `mem_if_pkg`: req_type encodings (REQ_FETCH, REQ_LOAD, REQ_STORE), FSM state enum, ADDR_W default.
- No sub-module is needed. acc_cnt is an inline counter; the FSM, address registers and response register stay in one module.

Test Plan:
- Fetch addr 0x10 with RAM[0x10]=0x8C010004 and resp_ready=1. Required: ISSUE cycle has MemRead=1, IorD=0, PC=0x10; next cycle has IRWrite=1 for exactly 1 cycle; resp_valid 3 cycles after accept; IR in the memory block = 0x8C010004; acc_cnt=1.
- Store addr 0x20 wdata 0xDEADBEEF, then load 0x20. Required: MemWrite high for exactly 1 cycle with IorD=1 and ALUOut=0x20; load returns resp_data=0xDEADBEEF with resp_err=0.
- Load addr 0x200 (RANGE_CHECK=1) and req_type=11. Required: resp_err=1 one cycle after accept; no strobe ever asserted; PC/ALUOut unchanged; acc_cnt unchanged.
- Backpressure: load 0x05 with resp_ready=0 for 5 cycles. Required: resp_valid and resp_data held stable; req_ready=0 throughout; one handshake then IDLE. A req_valid offered during the stall is not accepted.
- rst asserted in a store's ISSUE cycle. Required: MemWrite=0 that cycle, so the RAM word is unchanged on a later load; all outputs at reset values the cycle after; the next request completes normally.
- Preload acc_cnt to all-ones via 2^CNT_W−1 accesses (or CNT_W=4 build), then one more load. Required: acc_cnt wraps to 0.
